// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   // IDLE: one cycle after reset. FETCH: request on the bus.
   // HOLD: a response is parked while decode is stalled.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
//
// Handshake: the master raises imemReqOutput with imemAddrOutput and keeps
// both stable until the slave returns imemReadyInput=1. imemDataInput is
// valid only in that ready cycle, and that cycle completes the request.
// Ready while req=0 is ignored. A request may be abandoned at any time by
// reset, so the slave must not rely on seeing every request completed.
interface instruction_fetch_stage_if #(
   parameter int ADDR_W = 32
) ();
   logic              imemReqOutput;
   logic [ADDR_W-1:0] imemAddrOutput;
   logic              imemReadyInput;
   logic [31:0]       imemDataInput;

   modport master (
      output imemReqOutput, imemAddrOutput,
      input  imemReadyInput, imemDataInput
   );

   modport slave (
      input  imemReqOutput, imemAddrOutput,
      output imemReadyInput, imemDataInput
   );
endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry buffer holding {instr, pc4} for a response that arrived while
// decode was stalled. load wins over drop.
module fetch_hold_buffer
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              drop,
   input  logic [31:0]       instr_in,
   input  logic [ADDR_W-1:0] pc4_in,
   output logic              valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc4
);

   // Capture a parked response, or empty the entry once it is consumed or killed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc4   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc4   <= pc4_in;
      end else if (drop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, imem request sequencing, redirect selection
// and the IF/ID pipeline register.
// Optional build macro FETCH_PERF_COUNTERS_EN adds fetch/stall counters.
module instruction_fetch_stage
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic                       clk,
   input  logic                       reset,
   instruction_fetch_stage_if.master  imem,
   input  logic                       jumpInput,
   input  logic [ADDR_W-1:0]          pcJumpInput,
   input  logic                       branchTakenInput,
   input  logic [ADDR_W-1:0]          pcBranchInput,
   input  logic                       stallInput,
   input  logic                       flushInput,
   output logic [31:0]                instructionOutput,
   output logic [ADDR_W-1:0]          pc4Output,
   output logic                       validOutput,
`ifdef FETCH_PERF_COUNTERS_EN
   output logic [31:0]                fetchCountOutput,
   output logic [31:0]                stallCycleCountOutput,
`endif
   output fetch_state_t               stateOutput
);

   fetch_state_t      state;
   logic              req_q;
   logic              killed;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc4_q;
   logic              valid_q;

   logic              redirect;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] seq_pc;
   logic              take_rsp;
   logic              buf_load;
   logic              buf_drop;
   logic              buf_valid;
   logic [31:0]       buf_instr;
   logic [ADDR_W-1:0] buf_pc4;

   // A taken branch always redirects; a jump only when decode is not stalled,
   // because a stalled decode presents the jump again later.
   assign redirect = branchTakenInput | (jumpInput & ~stallInput);
   assign target   = branchTakenInput ? pcBranchInput : pcJumpInput;
   assign seq_pc   = addr_reg + ADDR_W'(4);

   // A response that is kept: not from a killed request and not overtaken by
   // a redirect in the same cycle.
   assign take_rsp = (state == FETCH) & imem.imemReadyInput & ~killed & ~redirect;
   assign buf_load = take_rsp & stallInput;
   assign buf_drop = (state == HOLD) & (redirect | ~stallInput);

   fetch_hold_buffer #(.ADDR_W(ADDR_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (buf_load),
      .drop     (buf_drop),
      .instr_in (imem.imemDataInput),
      .pc4_in   (seq_pc),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .pc4      (buf_pc4)
   );

   // Fetch FSM, PC/address registers and IF/ID register. Flush is applied
   // first so that a same-cycle load of a new instruction overrides it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         req_q    <= 1'b0;
         killed   <= 1'b0;
         pc       <= RESET_PC;
         addr_reg <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc4_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (flushInput) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
         end
         case (state)
            IDLE: begin
               state <= FETCH;
               req_q <= 1'b1;
               if (redirect) begin
                  pc       <= target;
                  addr_reg <= target;
                  instr_q  <= NOP_INSTR;
                  valid_q  <= 1'b0;
               end
            end
            FETCH: begin
               if (redirect) begin
                  pc      <= target;
                  instr_q <= NOP_INSTR;
                  valid_q <= 1'b0;
                  if (imem.imemReadyInput) begin
                     addr_reg <= target;
                     killed   <= 1'b0;
                  end else begin
                     killed <= 1'b1;
                  end
               end else if (imem.imemReadyInput && killed) begin
                  addr_reg <= pc;
                  killed   <= 1'b0;
                  if (!stallInput) begin
                     instr_q <= NOP_INSTR;
                     valid_q <= 1'b0;
                  end
               end else if (take_rsp && stallInput) begin
                  state <= HOLD;
                  req_q <= 1'b0;
               end else if (take_rsp) begin
                  instr_q  <= imem.imemDataInput;
                  pc4_q    <= seq_pc;
                  valid_q  <= 1'b1;
                  pc       <= seq_pc;
                  addr_reg <= seq_pc;
               end else if (!stallInput) begin
                  instr_q <= NOP_INSTR;
                  valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc       <= target;
                  addr_reg <= target;
                  state    <= FETCH;
                  req_q    <= 1'b1;
                  instr_q  <= NOP_INSTR;
                  valid_q  <= 1'b0;
               end else if (!stallInput) begin
                  instr_q  <= buf_instr;
                  pc4_q    <= buf_pc4;
                  valid_q  <= buf_valid;
                  pc       <= seq_pc;
                  addr_reg <= seq_pc;
                  state    <= FETCH;
                  req_q    <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imemReqOutput  = req_q;
   assign imem.imemAddrOutput = addr_reg;
   assign instructionOutput   = instr_q;
   assign pc4Output           = pc4_q;
   assign validOutput         = valid_q;
   assign stateOutput         = state;

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   // Count kept responses and stalled cycles; both wrap at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (take_rsp) fetch_cnt <= fetch_cnt + 32'd1;
         if (stallInput) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign fetchCountOutput      = fetch_cnt;
   assign stallCycleCountOutput = stall_cnt;
`else
   // Counter-free build: no extra state or outputs.
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. Memory returns
// 32'h2001_0005 + address whenever ready is driven high.
module tb_instruction_fetch_stage;
   import fetch_pkg::*;

   logic              clk;
   logic              reset;
   logic              mem_ready;
   logic              jump;
   logic [31:0]       pc_jump;
   logic              branch;
   logic [31:0]       pc_branch;
   logic              stall;
   logic              flush;
   logic [31:0]       instr;
   logic [31:0]       pc4;
   logic              valid;
   fetch_state_t      state_dbg;

   int checks;
   int failures;

   instruction_fetch_stage_if #(.ADDR_W(32)) bus ();

   instruction_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk               (clk),
      .reset             (reset),
      .imem              (bus),
      .jumpInput         (jump),
      .pcJumpInput       (pc_jump),
      .branchTakenInput  (branch),
      .pcBranchInput     (pc_branch),
      .stallInput        (stall),
      .flushInput        (flush),
      .instructionOutput (instr),
      .pc4Output         (pc4),
      .validOutput       (valid),
      .stateOutput       (state_dbg)
   );

   // Memory model.
   assign bus.imemReadyInput = mem_ready;
   assign bus.imemDataInput  = 32'h2001_0005 + bus.imemAddrOutput;

   // Observation word: {state, req, addr, valid, pc4, instr}.
   logic [99:0] obs;
   assign obs = {state_dbg, bus.imemReqOutput, bus.imemAddrOutput, valid, pc4, instr};

   // Clock / reset block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [99:0] exp;
      reset = 1'b0; mem_ready = 1'b1; jump = 1'b0; pc_jump = '0;
      branch = 1'b0; pc_branch = '0; stall = 1'b0; flush = 1'b0;
      tick(); tick();
      exp = {IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
      reset = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_back_to_back();
      logic [99:0] exp_t [2];
      exp_t[0] = {FETCH, 1'b1, 32'h4, 1'b1, 32'h4, 32'h2001_0005};
      exp_t[1] = {FETCH, 1'b1, 32'h8, 1'b1, 32'h8, 32'h2001_0009};
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== exp_t[i]) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, obs, exp_t[i]); end
      end
   endtask

   task automatic test_ready_wait();
      logic [99:0] exp;
      mem_ready = 1'b0;
      exp = {FETCH, 1'b1, 32'h8, 1'b0, 32'h8, 32'h0};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL wait_%0d got=%h exp=%h", i, obs, exp); end
      end
      mem_ready = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'hC, 1'b1, 32'hC, 32'h2001_000D};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL wait_deliver got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_stall_hold();
      logic [99:0] exp;
      stall = 1'b1;
      exp = {HOLD, 1'b0, 32'hC, 1'b1, 32'hC, 32'h2001_000D};
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL hold_%0d got=%h exp=%h", i, obs, exp); end
      end
      stall = 1'b0;
      tick();
      exp = {FETCH, 1'b1, 32'h10, 1'b1, 32'h10, 32'h2001_0011};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL hold_release got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_branch_kill();
      logic [99:0] exp;
      tick();
      exp = {FETCH, 1'b1, 32'h14, 1'b1, 32'h14, 32'h2001_0015};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_pre got=%h exp=%h", obs, exp); end
      mem_ready = 1'b0;
      tick();
      exp = {FETCH, 1'b1, 32'h14, 1'b0, 32'h14, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_wait got=%h exp=%h", obs, exp); end
      branch = 1'b1; pc_branch = 32'h40;
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_outstanding got=%h exp=%h", obs, exp); end
      branch = 1'b0; mem_ready = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'h40, 1'b0, 32'h14, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_discard got=%h exp=%h", obs, exp); end
      tick();
      exp = {FETCH, 1'b1, 32'h44, 1'b1, 32'h44, 32'h2001_0045};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_target got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_jump();
      logic [99:0] exp;
      mem_ready = 1'b0; stall = 1'b1; jump = 1'b1; pc_jump = 32'h100;
      tick();
      exp = {FETCH, 1'b1, 32'h44, 1'b1, 32'h44, 32'h2001_0045};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL jmp_stalled got=%h exp=%h", obs, exp); end
      jump = 1'b0; stall = 1'b0; mem_ready = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'h48, 1'b1, 32'h48, 32'h2001_0049};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL jmp_ignored got=%h exp=%h", obs, exp); end
      jump = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'h100, 1'b0, 32'h48, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL jmp_taken got=%h exp=%h", obs, exp); end
      pc_jump = 32'h300; branch = 1'b1; pc_branch = 32'h200;
      tick();
      exp = {FETCH, 1'b1, 32'h200, 1'b0, 32'h48, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL jmp_vs_branch got=%h exp=%h", obs, exp); end
      jump = 1'b0; branch = 1'b0;
      tick();
      exp = {FETCH, 1'b1, 32'h204, 1'b1, 32'h204, 32'h2001_0205};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL jmp_after got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_flush();
      logic [99:0] exp;
      flush = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'h208, 1'b1, 32'h208, 32'h2001_0209};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL flush_keep_rsp got=%h exp=%h", obs, exp); end
      stall = 1'b1; mem_ready = 1'b0;
      tick();
      exp = {FETCH, 1'b1, 32'h208, 1'b0, 32'h208, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL flush_over_stall got=%h exp=%h", obs, exp); end
      flush = 1'b0;
   endtask

   task automatic test_wrap();
      logic [99:0] exp;
      branch = 1'b1; pc_branch = 32'hFFFF_FFFC; mem_ready = 1'b1;
      tick();
      exp = {FETCH, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h208, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL branch_in_stall got=%h exp=%h", obs, exp); end
      branch = 1'b0; stall = 1'b0;
      tick();
      exp = {FETCH, 1'b1, 32'h0, 1'b1, 32'h0, 32'h2001_0001};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL wrap got=%h exp=%h", obs, exp); end
      tick();
      exp = {FETCH, 1'b1, 32'h4, 1'b1, 32'h4, 32'h2001_0005};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL wrap_next got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_reset_mid();
      logic [99:0] exp;
      mem_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      exp = {IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs, exp); end
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_back_to_back();
      test_ready_wait();
      test_stall_hold();
      test_branch_kill();
      test_jump();
      test_flush();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Upstream neighbour of the decode stage. Holds the PC, fetches from instruction memory over a req/ready handshake, and selects the next PC from sequential, jump or branch redirect. Drives the IF/ID pipeline register (instruction, pc+4, valid) consumed by decode, and honours stall/flush from hazard control.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
ADDR_W, 32, PC/address width; pc+4 wraps modulo 2^ADDR_W.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
imemReqOutput  output  1  fetch request.
imemAddrOutput  output  ADDR_W  fetch address; stable while req=1 and ready=0.
imemReadyInput  input  1  memory response valid this cycle.
imemDataInput  input  32  instruction word, valid when ready=1.
jumpInput  input  1  jump redirect from decode.
pcJumpInput  input  ADDR_W  jump target.
branchTakenInput  input  1  taken-branch redirect from execute.
pcBranchInput  input  ADDR_W  branch target.
stallInput  input  1  hold PC and IF/ID register.
flushInput  input  1  clear IF/ID register to bubble.
instructionOutput  output  32  IF/ID instruction; 0 (NOP) when invalid.
pc4Output  output  ADDR_W  IF/ID pc+4.
validOutput  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, killed=0, imemReqOutput=0, imemAddrOutput=RESET_PC, instructionOutput=0, pc4Output=0, validOutput=0, hold buffer empty.
- States: IDLE -> FETCH unconditionally on first clock after reset release. FETCH: req=1, addr=addrReg. HOLD: req=0, response buffered, waiting for stall to drop.
- FETCH, ready=1, killed=0, no redirect, stall=0: IF/ID <= {imemData, addrReg+4, valid=1}; pc, addrReg <= addrReg+4; stay FETCH (back-to-back fetch, 1 instruction/cycle when ready held high).
- FETCH, ready=1, stall=1: response -> hold buffer, IF/ID unchanged, -> HOLD.
- HOLD, stall=0: buffer -> IF/ID, pc <= pc+4, -> FETCH with new address next cycle.
- FETCH, ready=0, stall=0: IF/ID <= bubble (valid=0, instr=0, pc4 unchanged).
- Redirect priority: branchTaken > jump > sequential. Taken branch: pc <= pcBranch and IF/ID <= bubble, accepted even when stall=1. Jump: pc <= pcJump, ignored when stall=1 (decode re-presents it); IF/ID takes a bubble.
- Redirect while a request is outstanding (req=1, ready=0): addrReg unchanged, killed <= 1; the response is discarded on ready, killed <= 0, next cycle req at the new pc.
- Redirect in the same cycle as ready=1: response discarded, next fetch at target.
- Redirect in HOLD: buffer dropped, -> FETCH at target.
- flushInput: IF/ID <= bubble; wins over stall; does not change pc or the in-flight fetch.
- Simultaneous flush + valid response with stall=0: response is not lost; it is written to IF/ID after the flush (flush applies to the current IF/ID contents).
- Reset asserted mid-request: req drops asynchronously; the memory model must tolerate an abandoned request.

Optional Feature:
FETCH_PERF_COUNTERS_EN: adds outputs fetchCountOutput[31:0] (accepted, non-killed responses) and stallCycleCountOutput[31:0] (cycles with stallInput=1). Both reset to 0 and wrap at 2^32. Without the macro: ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, FETCH, HOLD}; NOP_INSTR=32'h0; default RESET_PC constant.
- Sub-module fetch_hold_buffer: 1-entry buffer {instr, pc4} with load/drop/valid; one natural split.

Test Plan:
- Release reset, ready tied 1, data = 32'h2001_0005 onwards -> addr sequence 0,4,8,...; first validOutput=1 two cycles after release; pc4Output=4.
- Ready low 3 cycles on addr 8 -> addr held at 8, req=1, validOutput=0 for 3 cycles, then instr delivered with pc4=12.
- stall=1 when response for addr 12 arrives -> IF/ID unchanged, req=0 (HOLD); stall drops -> IF/ID = that instr with pc4=16, next addr 16.
- branchTaken=1, pcBranch=32'h40, while a fetch to 0x14 is outstanding -> response discarded, IF/ID bubble, next req addr=0x40.
- jump=1, pcJump=32'h100 with stall=1 -> ignored; same with stall=0 -> next addr 0x100; branch+jump in the same cycle -> branch target wins.
- pc=32'hFFFF_FFFC sequential fetch -> pc4Output=0, next addr 0 (wrap); assert reset mid-request -> all outputs at reset values immediately.
